// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: divider FSM state encoding and the default operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 4;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and keep or restore the partial remainder.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   carry;

  // rem_in is always below the divisor, so the WIDTH+1-bit shifted value holds it exactly.
  assign shifted  = {rem_in, dvd_bit};
  assign sub_b    = ~divisor;
  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sub
    full_adder u_fa (
      .a    (shifted[gi]),
      .b    (sub_b[gi]),
      .cin  (carry[gi]),
      .sum  (diff[gi]),
      .cout (carry[gi+1])
    );
  end

  // Top subtractor bit sees an inverted zero (b=1), so its carry-out reduces to a|cin:
  // carry-out set means no borrow, i.e. the trial difference is non-negative.
  assign q_bit   = shifted[WIDTH] | carry[WIDTH];
  assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple subtractor in div_step.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock behind a start/done handshake.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] aq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             zero_div;
  logic             accept, step, finish;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem),
    .dvd_bit (aq[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter and registered handshake/result outputs; a zero divisor spends a single
  // RUN cycle so its done pulse lands one edge after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (accept) begin
        cnt <= (divisor == '0) ? '0 : CW'(WIDTH - 1);
      end else if (step) begin
        cnt <= cnt - CW'(1);
      end
      if (finish) begin
        if (zero_div) begin
          quotient    <= '1;
          remainder   <= aq;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= {aq[WIDTH-2:0], q_bit};
          remainder   <= rem_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

  // Operand/quotient datapath: the dividend shifts out of aq's MSB while quotient bits enter its LSB.
  always_ff @(posedge clk) begin
    if (accept) begin
      aq       <= dividend;
      dvs      <= divisor;
      prem     <= '0;
      zero_div <= (divisor == '0);
    end else if (step) begin
      aq   <= {aq[WIDTH-2:0], q_bit};
      prem <= rem_next;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, hand-written corner sequences and a full sweep,
// with results scored against a queue of expected values.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Results are scored whenever the DUT pulses done.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.z));
      end
    end
  end

  task automatic push_exp(input int q, input int r, input int z);
    exp_t e;
    e.q = q[3:0];
    e.r = r[3:0];
    e.z = z[0];
    sb.push_back(e);
  endtask

  // Called #1 after the capture edge; returns edges until done and busy samples seen on the way.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
    end
  endtask

  task automatic do_op(input int a, input int b, input int q, input int r, input int z);
    int cyc, bcnt;
    @(negedge clk);
    start    = 1'b1;
    dividend = a[3:0];
    divisor  = b[3:0];
    push_exp(q, r, z);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    chk("latency", cyc, (b == 0) ? 1 : 4);
    if (b != 0) chk("busy_cycles", bcnt, 4);
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   cyc, bcnt;

    vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1,  z: 0};
    vecs[1] = '{a: 7,  b: 0,  q: 15, r: 7,  z: 1};
    vecs[2] = '{a: 15, b: 1,  q: 15, r: 0,  z: 0};
    vecs[3] = '{a: 2,  b: 9,  q: 0,  r: 2,  z: 0};
    vecs[4] = '{a: 15, b: 15, q: 1,  r: 0,  z: 0};
    vecs[5] = '{a: 0,  b: 7,  q: 0,  r: 0,  z: 0};
    vecs[6] = '{a: 15, b: 0,  q: 15, r: 15, z: 1};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Back-to-back: start held through DONE; operand change during RUN must be ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    push_exp(2, 2, 0);
    @(posedge clk);
    #1;
    dividend = 4'd9;
    divisor  = 4'd2;
    wait_done(cyc, bcnt);
    chk("b2b_first_latency", cyc, 4);
    push_exp(4, 1, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_no_idle_busy", int'(busy), 1);
    chk("b2b_done_cleared", int'(done), 0);
    wait_done(cyc, bcnt);
    chk("b2b_second_latency", cyc, 4);
    @(posedge clk);
    #1;

    // Start pulsed mid-RUN with other operands: ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd11;
    divisor  = 4'd2;
    push_exp(5, 1, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    chk("midrun_start_latency", cyc + 2, 4);
    repeat (6) @(posedge clk);
    #1;
    chk("midrun_idle", int'(busy), 0);

    // Asynchronous reset during the second RUN cycle.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_quotient", int'(quotient), 0);
    chk("arst_remainder", int'(remainder), 0);
    chk("arst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(10, 3, 3, 1, 0);

    // Full operand sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) do_op(a, b, 15, a, 1);
        else        do_op(a, b, a / b, a % b, 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
